// File: rtl/munch_frame_sequencer.sv
// Frame-rate controller for the munching-squares renderer.
// Sequences the animation frame counter on VSync rising edges (run, hold,
// single-step, direction, speed division) and commits the persistence lag.
// All configuration is sampled only on frame edges so the picture never tears.
module munch_frame_sequencer #(
  parameter int unsigned FRAME_BITS = 9,
  parameter int unsigned DIV_BITS   = 3,
  parameter int unsigned MAX_LAG    = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  vsync,
  input  logic                  cfg_run,
  input  logic                  cfg_step,
  input  logic                  cfg_dir,
  input  logic [DIV_BITS-1:0]   cfg_div,
  input  logic [3:0]            cfg_lag,
  output logic [FRAME_BITS-1:0] frame_no,
  output logic [3:0]            lag_len,
  output logic                  frame_tick,
  output logic [1:0]            state
);

  localparam logic [3:0] LAG_CAP = 4'(MAX_LAG);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10
  } state_t;

  state_t                cur_state, nxt_state;
  logic                  prev_vsync, prev_step, step_pending;
  logic [DIV_BITS-1:0]   div_cnt;
  logic [FRAME_BITS-1:0] frame_nxt;
  logic [3:0]            lag_nxt, lag_sel;
  logic [DIV_BITS-1:0]   div_nxt;
  logic                  step_nxt, tick_nxt;
  logic                  frame_edge, step_req, advance;

  assign state = cur_state;

  // State and output registers; everything returns to its idle value on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state    <= IDLE;
      prev_vsync   <= 1'b1;
      prev_step    <= 1'b0;
      step_pending <= 1'b0;
      div_cnt      <= '0;
      frame_no     <= '0;
      lag_len      <= LAG_CAP;
      frame_tick   <= 1'b0;
    end else begin
      cur_state    <= nxt_state;
      prev_vsync   <= vsync;
      prev_step    <= cfg_step;
      step_pending <= step_nxt;
      div_cnt      <= div_nxt;
      frame_no     <= frame_nxt;
      lag_len      <= lag_nxt;
      frame_tick   <= tick_nxt;
    end
  end

  // Frame-edge decision: next state, divider, step bookkeeping and advance.
  always_comb begin
    nxt_state  = cur_state;
    div_nxt    = div_cnt;
    frame_nxt  = frame_no;
    lag_nxt    = lag_len;
    tick_nxt   = 1'b0;
    advance    = 1'b0;
    frame_edge = vsync & ~prev_vsync;
    // A step rise on the edge cycle itself is honoured by that edge.
    step_req   = step_pending | (cfg_step & ~prev_step);
    step_nxt   = step_req;
    lag_sel    = (cfg_lag > LAG_CAP) ? LAG_CAP : cfg_lag;

    if (frame_edge) begin
      step_nxt = 1'b0;
      lag_nxt  = lag_sel;
      unique case (cur_state)
        IDLE: begin
          nxt_state = cfg_run ? RUN : HOLD;
          div_nxt   = '0;
        end
        RUN: begin
          if (cfg_run) begin
            // >= so a divider lowered below the running count fires at once.
            if (div_cnt >= cfg_div) begin
              advance = 1'b1;
              div_nxt = '0;
            end else begin
              div_nxt = div_cnt + DIV_BITS'(1);
            end
          end else begin
            nxt_state = HOLD;
            div_nxt   = '0;
          end
        end
        HOLD: begin
          if (cfg_run) begin
            nxt_state = RUN;
            div_nxt   = '0;
          end else if (step_req) begin
            advance = 1'b1;
          end
        end
        default: nxt_state = IDLE;
      endcase
    end

    if (advance) begin
      frame_nxt = cfg_dir ? frame_no - FRAME_BITS'(1) : frame_no + FRAME_BITS'(1);
      tick_nxt  = 1'b1;
    end
  end

endmodule

// File: tb/tb_munch_frame_sequencer.sv
// Self-checking bench for munch_frame_sequencer: a vector table for the basic
// run/hold/step flow, then hand-written multi-cycle sequences.
module tb_munch_frame_sequencer;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_HOLD = 2'b10;

  logic       clk = 1'b0;
  logic       reset, vsync, cfg_run, cfg_step, cfg_dir;
  logic [2:0] cfg_div;
  logic [3:0] cfg_lag;
  logic [8:0] frame_no, frame_no10;
  logic [3:0] lag_len, lag_len10;
  logic       frame_tick, frame_tick10;
  logic [1:0] state, state10;

  always #5 clk = ~clk;

  munch_frame_sequencer dut (
    .clk(clk), .reset(reset), .vsync(vsync), .cfg_run(cfg_run),
    .cfg_step(cfg_step), .cfg_dir(cfg_dir), .cfg_div(cfg_div), .cfg_lag(cfg_lag),
    .frame_no(frame_no), .lag_len(lag_len), .frame_tick(frame_tick), .state(state)
  );

  munch_frame_sequencer #(.MAX_LAG(10)) dut10 (
    .clk(clk), .reset(reset), .vsync(vsync), .cfg_run(cfg_run),
    .cfg_step(cfg_step), .cfg_dir(cfg_dir), .cfg_div(cfg_div), .cfg_lag(cfg_lag),
    .frame_no(frame_no10), .lag_len(lag_len10), .frame_tick(frame_tick10), .state(state10)
  );

  typedef struct packed {
    logic [8:0] frame;
    logic [3:0] lag;
    logic       tick;
    logic [1:0] st;
  } exp_t;

  typedef struct {
    logic       rst, vs, run, step, dir;
    logic [2:0] div;
    logic [3:0] lag;
    logic [8:0] ef;
    logic [3:0] el;
    logic       et;
    logic [1:0] es;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[14];
  int   checks = 0;
  int   errors = 0;
  int   cycle_no = 0;

  // Drive vsync for one cycle, queue the expected outputs, then check them.
  task automatic cyc(input logic vs, input logic [8:0] ef, input logic [3:0] el,
                     input logic et, input logic [1:0] es);
    exp_t e;
    vsync   = vs;
    e.frame = ef;
    e.lag   = el;
    e.tick  = et;
    e.st    = es;
    sb.push_back(e);
    @(posedge clk);
    #1;
    cycle_no++;
    e = sb.pop_front();
    checks++;
    if (frame_no !== e.frame || lag_len !== e.lag || frame_tick !== e.tick || state !== e.st) begin
      errors++;
      $display("FAIL outputs cycle %0d: got frame=%0d lag=%0d tick=%0b state=%0b, want frame=%0d lag=%0d tick=%0b state=%0b",
               cycle_no, frame_no, lag_len, frame_tick, state, e.frame, e.lag, e.tick, e.st);
    end
  endtask

  task automatic chk10(input logic [3:0] el);
    checks++;
    if (lag_len10 !== el) begin
      errors++;
      $display("FAIL lag_clamp10 cycle %0d: got lag=%0d, want %0d", cycle_no, lag_len10, el);
    end
  endtask

  initial begin
    logic [8:0] f;
    logic       adv;
    int         nticks;

    // rst vs run step dir div lag | frame lag tick state
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'd5, 9'd0, 4'd15, 1'b0, S_IDLE};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'd5, 9'd0, 4'd15, 1'b0, S_IDLE};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 4'd5, 9'd0, 4'd5,  1'b0, S_RUN};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 4'd5, 9'd0, 4'd5,  1'b0, S_RUN};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'd5, 9'd0, 4'd5,  1'b0, S_RUN};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 4'd5, 9'd1, 4'd5,  1'b1, S_RUN};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'd5, 9'd1, 4'd5,  1'b0, S_RUN};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 4'd5, 9'd2, 4'd5,  1'b1, S_RUN};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'd5, 9'd2, 4'd5,  1'b0, S_RUN};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd5, 9'd2, 4'd5,  1'b0, S_HOLD};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd5, 9'd2, 4'd5,  1'b0, S_HOLD};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 4'd5, 9'd3, 4'd5,  1'b1, S_HOLD};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd5, 9'd3, 4'd5,  1'b0, S_HOLD};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd5, 9'd3, 4'd5,  1'b0, S_HOLD};

    reset = 1'b1; vsync = 1'b0; cfg_run = 1'b0; cfg_step = 1'b0;
    cfg_dir = 1'b0; cfg_div = 3'd0; cfg_lag = 4'd0;

    for (int i = 0; i < 14; i++) begin
      reset    = tbl[i].rst;
      cfg_run  = tbl[i].run;
      cfg_step = tbl[i].step;
      cfg_dir  = tbl[i].dir;
      cfg_div  = tbl[i].div;
      cfg_lag  = tbl[i].lag;
      cyc(tbl[i].vs, tbl[i].ef, tbl[i].el, tbl[i].et, tbl[i].es);
    end

    // Divide-by-3 run: advance on the 3rd and 6th edge after entering RUN.
    cfg_run = 1'b1; cfg_div = 3'd2; cfg_dir = 1'b0;
    cyc(1'b0, 9'd3, 4'd5, 1'b0, S_HOLD);
    cyc(1'b1, 9'd3, 4'd5, 1'b0, S_RUN);
    f = 9'd3;
    nticks = 0;
    for (int i = 1; i <= 7; i++) begin
      adv = (i % 3 == 0);
      cyc(1'b0, f, 4'd5, 1'b0, S_RUN);
      if (adv) f = f + 9'd1;
      cyc(1'b1, f, 4'd5, adv, S_RUN);
      if (frame_tick) nticks++;
    end
    checks++;
    if (nticks != 2) begin
      errors++;
      $display("FAIL div_tick_count: got %0d ticks, want 2", nticks);
    end

    // Divider lowered below the running count fires immediately.
    cfg_div = 3'd0;
    cyc(1'b0, 9'd5, 4'd5, 1'b0, S_RUN);
    cyc(1'b1, 9'd6, 4'd5, 1'b1, S_RUN);

    // Run up to frame 37.
    f = 9'd6;
    for (int i = 0; i < 31; i++) begin
      cyc(1'b0, f, 4'd5, 1'b0, S_RUN);
      f = f + 9'd1;
      cyc(1'b1, f, 4'd5, 1'b1, S_RUN);
    end

    // Reset with vsync held high; release must not produce an edge.
    reset = 1'b1;
    cyc(1'b1, 9'd0, 4'd15, 1'b0, S_IDLE);
    chk10(4'd10);
    reset = 1'b0;
    repeat (3) cyc(1'b1, 9'd0, 4'd15, 1'b0, S_IDLE);

    // Step while IDLE is discarded by the first edge.
    cfg_run = 1'b0; cfg_step = 1'b1;
    cyc(1'b0, 9'd0, 4'd15, 1'b0, S_IDLE);
    cfg_step = 1'b0;
    cyc(1'b0, 9'd0, 4'd15, 1'b0, S_IDLE);
    cyc(1'b1, 9'd0, 4'd5, 1'b0, S_HOLD);
    cyc(1'b0, 9'd0, 4'd5, 1'b0, S_HOLD);
    cyc(1'b1, 9'd0, 4'd5, 1'b0, S_HOLD);

    // Single step backwards wraps 0 -> 511.
    cfg_dir = 1'b1; cfg_step = 1'b1;
    cyc(1'b0, 9'd0, 4'd5, 1'b0, S_HOLD);
    cfg_step = 1'b0;
    cyc(1'b0, 9'd0, 4'd5, 1'b0, S_HOLD);
    cyc(1'b1, 9'd511, 4'd5, 1'b1, S_HOLD);

    // Three step pulses in one frame give one advance.
    for (int k = 0; k < 3; k++) begin
      cfg_step = 1'b1;
      cyc(1'b0, 9'd511, 4'd5, 1'b0, S_HOLD);
      cfg_step = 1'b0;
      cyc(1'b0, 9'd511, 4'd5, 1'b0, S_HOLD);
    end
    cyc(1'b1, 9'd510, 4'd5, 1'b1, S_HOLD);

    // No step: frozen across five edges.
    repeat (5) begin
      cyc(1'b0, 9'd510, 4'd5, 1'b0, S_HOLD);
      cyc(1'b1, 9'd510, 4'd5, 1'b0, S_HOLD);
    end

    // Lag changes only take effect at a frame edge; clamp on the MAX_LAG=10 copy.
    cfg_lag = 4'd3;
    cyc(1'b0, 9'd510, 4'd5, 1'b0, S_HOLD);
    cyc(1'b1, 9'd510, 4'd3, 1'b0, S_HOLD);
    cfg_lag = 4'd9;
    repeat (3) cyc(1'b0, 9'd510, 4'd3, 1'b0, S_HOLD);
    cyc(1'b1, 9'd510, 4'd9, 1'b0, S_HOLD);
    cfg_lag = 4'd15;
    cyc(1'b0, 9'd510, 4'd9, 1'b0, S_HOLD);
    cyc(1'b1, 9'd510, 4'd15, 1'b0, S_HOLD);
    chk10(4'd10);
    cfg_lag = 4'd7;
    cyc(1'b0, 9'd510, 4'd15, 1'b0, S_HOLD);
    cyc(1'b1, 9'd510, 4'd7, 1'b0, S_HOLD);
    chk10(4'd7);

    // cfg_run rising on the edge cycle: enter RUN without advancing.
    cyc(1'b0, 9'd510, 4'd7, 1'b0, S_HOLD);
    cfg_run = 1'b1;
    cyc(1'b1, 9'd510, 4'd7, 1'b0, S_RUN);
    cyc(1'b0, 9'd510, 4'd7, 1'b0, S_RUN);
    cyc(1'b1, 9'd509, 4'd7, 1'b1, S_RUN);

    // Steps while running are ignored and not carried into HOLD.
    cfg_step = 1'b1;
    cyc(1'b0, 9'd509, 4'd7, 1'b0, S_RUN);
    cfg_step = 1'b0;
    cyc(1'b0, 9'd509, 4'd7, 1'b0, S_RUN);
    cfg_run = 1'b0;
    cyc(1'b1, 9'd509, 4'd7, 1'b0, S_HOLD);
    cyc(1'b0, 9'd509, 4'd7, 1'b0, S_HOLD);
    cyc(1'b1, 9'd509, 4'd7, 1'b0, S_HOLD);

    // Forward steps wrap 511 -> 0.
    cfg_dir = 1'b0;
    f = 9'd509;
    repeat (3) begin
      cfg_step = 1'b1;
      cyc(1'b0, f, 4'd7, 1'b0, S_HOLD);
      cfg_step = 1'b0;
      f = f + 9'd1;
      cyc(1'b1, f, 4'd7, 1'b1, S_HOLD);
    end
    cyc(1'b0, 9'd0, 4'd7, 1'b0, S_HOLD);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/munch_frame_sequencer.md
# munch_frame_sequencer

Frame-rate controller for the munching-squares renderer. It watches VSync from the sync generator and sequences the animation frame counter: run, hold, single-step, direction and speed division. It also supplies the active phosphor-persistence lag length. All user configuration is committed only at frame boundaries, so the picture never tears mid-frame.

## Interface

Parameters:
- FRAME_BITS, 9, width of frame counter; wraps modulo 2^FRAME_BITS
- DIV_BITS, 3, width of speed-divider setting
- MAX_LAG, 15, upper clamp for lag_len (1..15)

Ports:
- clk  in  1  system/pixel clock; the block uses one clock
- reset  in  1  synchronous, active-high reset
- vsync  in  1  VSync from sync generator (level)
- cfg_run  in  1  1 = animate, 0 = hold
- cfg_step  in  1  rising edge requests one-frame advance while holding
- cfg_dir  in  1  0 = increment, 1 = decrement
- cfg_div  in  DIV_BITS  advance once every cfg_div+1 frame edges
- cfg_lag  in  4  requested persistence depth
- frame_no  out  FRAME_BITS  current animation frame
- lag_len  out  4  committed lag, min(cfg_lag, MAX_LAG)
- frame_tick  out  1  one-cycle pulse, coincident with each frame_no change
- state  out  2  00 IDLE, 01 RUN, 10 HOLD

## Operation

- Frame edge (E): a cycle where vsync=1 and prev_vsync=0. prev_vsync is a register; its reset value is 1.
- Step request: cfg_step=1 with prev_step=0 (reset 0) sets sticky step_pending. Any number of rises between two frame edges counts as one request. A rise on an E cycle counts for that E.
- At E, cfg_run/cfg_dir/cfg_div/cfg_lag present in that cycle are committed and govern that edge's decision. lag_len updates at every E. Between edges, config inputs have no effect.
- div_cnt (DIV_BITS): counts edges in RUN.
- FSM:
  - IDLE (after reset): frame_no held. At E: go to RUN if cfg_run=1, else HOLD. No advance on this edge. step_pending is cleared.
  - RUN: at E with cfg_run=1: if div_cnt==cfg_div, advance and set div_cnt=0; else div_cnt+1. At E with cfg_run=0: go to HOLD, no advance, div_cnt=0. step_pending is cleared at every E in RUN; steps are ignored while running.
  - HOLD: at E with cfg_run=1: go to RUN, no advance, div_cnt=0, step_pending cleared. At E with cfg_run=0 and step_pending: advance once, clear step_pending, stay in HOLD.
- Advance: frame_no ± 1 modulo 2^FRAME_BITS (511+1→0; 0−1→511), and frame_tick=1 for one cycle.
- If cfg_div is lowered below div_cnt at an E, the edge is treated as div_cnt==cfg_div: advance and clear div_cnt. Compare with >=.
- Reset values: frame_no 0, lag_len MAX_LAG, frame_tick 0, state IDLE, div_cnt 0, step_pending 0, prev_vsync 1, prev_step 0.
- Reset mid-operation: all registers return to reset values at the next clk edge and any pending step is discarded. If vsync is held high through reset release, no E occurs until vsync falls and rises again.

## Timing

- Single clk domain. All outputs are registered, with no combinational input→output paths.
- Latency: E detected in cycle n. frame_no, lag_len, state and frame_tick reflect the decision in cycle n+1.
- frame_tick is high exactly in cycle n+1 and low otherwise. The block never produces two ticks closer than two vsync rising edges.
- vsync is treated as synchronous to clk; no synchroniser is included.
- Back-to-back E cycles cannot occur, because an edge requires prev_vsync=0. A vsync held high produces one E.

## Test plan

- Reset, then cfg_run=1, div=0, dir=0, and three vsync pulses → 1st E: state RUN, frame_no 0, no tick. 2nd E: frame_no 1 with a one-cycle tick at n+1. 3rd E: frame_no 2.
- RUN with div=2 over seven E → frame_no advances on the 3rd and 6th E after entering RUN only. Exactly two ticks.
- HOLD at frame_no 0 with cfg_dir=1 and one step pulse → next E gives frame_no 511 and one tick. Three step pulses within one frame → still exactly one advance. No pulse → frame_no frozen across 5 E.
- Config isolation: cfg_lag changes 3→9 mid-frame → lag_len stays 3 until the next E, then becomes 9 at n+1. With MAX_LAG=10, cfg_lag=15 → lag_len 10.
- Simultaneity: cfg_step rises in the E cycle while in HOLD → advance on that E. cfg_run 0→1 in the E cycle → state RUN, no advance on that edge.
- Reset asserted in RUN at frame_no 37 with vsync high → next cycle shows frame_no 0, state IDLE, lag_len MAX_LAG. Reset released with vsync still high → no E until a fresh low→high transition.
